// File: rtl/alu_share_arbiter_if.sv
// Purpose: request, response and ALU-side signals of the shared-ALU arbiter.
// Latency: wires only, no storage.
// Backpressure: req_ready gates requests, rsp_ready gates responses.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    // requester side
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req_op0;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [3:0]       req_op1;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;

    // ALU side
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    // response side
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic             busy;

    // arbiter view
    modport slave (
        input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
        input  alu_result, alu_zero, rsp_ready,
        output req_ready, alu_ctl, alu_a, alu_b,
        output rsp_valid, rsp_result, rsp_zero, rsp_err, busy
    );

    // requesters plus ALU view
    modport master (
        output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
        output alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_ctl, alu_a, alu_b,
        input  rsp_valid, rsp_result, rsp_zero, rsp_err, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational ALU between two requesters.
// Latency: accept at T, ALU evaluated at T+1, response valid from T+2 (min 3 cycles/op).
// Backpressure: one op in flight; req_ready only in IDLE; response held until rsp_ready of winner.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // one latched operation: code plus both operands
    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_req_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    state_t           state;
    logic             last_grant;   // requester that won the most recent grant
    logic             cur_grant;    // requester owning the op in flight
    alu_req_t         op_q;
    logic [1:0]       rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;
    logic             busy_q;

    alu_req_t         req0;
    alu_req_t         req1;
    alu_req_t         win_req;
    logic             win_idx;
    logic [1:0]       grant_vec;
    logic             op_legal;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: is_legal = 1'b1;
            default:                                       is_legal = 1'b0;
        endcase
    endfunction

    assign req0    = {bus.req_op0, bus.req_a0, bus.req_b0};
    assign req1    = {bus.req_op1, bus.req_a1, bus.req_b1};
    assign win_req = win_idx ? req1 : req0;

    // round-robin pick; a tie goes to whoever did not win last time
    always_comb begin
        win_idx   = 1'b0;
        grant_vec = 2'b00;
        if (state == IDLE && !reset) begin
            case (bus.req_valid)
                2'b01: begin
                    win_idx   = 1'b0;
                    grant_vec = 2'b01;
                end
                2'b10: begin
                    win_idx   = 1'b1;
                    grant_vec = 2'b10;
                end
                2'b11: begin
                    win_idx   = ~last_grant;
                    grant_vec = last_grant ? 2'b01 : 2'b10;
                end
                default: begin
                    win_idx   = 1'b0;
                    grant_vec = 2'b00;
                end
            endcase
        end
    end

    assign op_legal = is_legal(op_q.op);

    assign bus.req_ready  = grant_vec;
    assign bus.alu_ctl    = op_q.op;
    assign bus.alu_a      = op_q.a;
    assign bus.alu_b      = op_q.b;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;

    // control FSM: accept in IDLE, sample the ALU in EXEC, hold the response in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cur_grant    <= 1'b0;
            op_q         <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vec != 2'b00) begin
                        op_q       <= win_req;
                        cur_grant  <= win_idx;
                        last_grant <= win_idx;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_legal) begin
                        rsp_result_q <= bus.alu_result;
                        rsp_zero_q   <= bus.alu_zero;
                        rsp_err_q    <= 1'b0;
                    end else begin
                        // unknown code: never trust what the ALU returns for it
                        rsp_result_q <= '0;
                        rsp_zero_q   <= 1'b1;
                        rsp_err_q    <= 1'b1;
                    end
                    rsp_valid_q <= cur_grant ? 2'b10 : 2'b01;
                    state       <= RESP;
                end
                RESP: begin
                    // only the owner can retire the response
                    if (bus.rsp_ready[cur_grant]) begin
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // handshake invariants: a single response owner, never a response while idle
    a_rsp_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.rsp_valid));
    a_rsp_busy : assert property (@(posedge clk) disable iff (reset)
        (bus.rsp_valid != 2'b00) |-> bus.busy);
    a_ready_idle : assert property (@(posedge clk) disable iff (reset)
        (bus.req_ready != 2'b00) |-> !bus.busy);

endmodule
